// File: rtl/sym_fir_stream.sv
// Streaming symmetric FIR: folded pre-add, per-pair multiply, adder tree, then round/shift/saturate.
// One ready/valid advance signal moves the delay line and all four pipeline stages together.
module sym_fir_stream #(
    parameter int DATA_WIDTH  = 12,
    parameter int COEFF_WIDTH = 8,
    parameter int TAPS        = 12,
    parameter int OUT_WIDTH   = 24,
    parameter int SHIFT       = 0,
    localparam int U  = (TAPS + 1) / 2,
    localparam int AW = (U > 1) ? $clog2(U) : 1
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          coeff_we,
    input  logic [AW-1:0]                 coeff_addr,
    input  logic signed [COEFF_WIDTH-1:0] coeff_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DATA_WIDTH-1:0]  in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OUT_WIDTH-1:0]   out_data,
    output logic                          sat_flag
);

    localparam int HALF = TAPS / 2;
    localparam int W1   = DATA_WIDTH + 1;
    localparam int W2   = DATA_WIDTH + COEFF_WIDTH + 1;
    localparam int W3   = W2 + $clog2(U);
    localparam int RW   = (W3 + 1 > OUT_WIDTH) ? W3 + 1 : OUT_WIDTH + 1;
    localparam int RSH  = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [RW-1:0] RND  = (SHIFT > 0) ? (RW'(1) << RSH) : RW'(0);
    localparam logic signed [RW-1:0] MAXV = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] MINV = {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    function automatic logic signed [RW-1:0] f_round(input logic signed [W3-1:0] v);
        logic signed [RW-1:0] t;
        t = RW'(v) + RND;
        return t >>> SHIFT;
    endfunction

    // Returns {clipped, value}.
    function automatic logic [OUT_WIDTH:0] f_sat(input logic signed [RW-1:0] v);
        if (v > MAXV)
            return {1'b1, MAXV[OUT_WIDTH-1:0]};
        else if (v < MINV)
            return {1'b1, MINV[OUT_WIDTH-1:0]};
        else
            return {1'b0, v[OUT_WIDTH-1:0]};
    endfunction

    logic signed [COEFF_WIDTH-1:0] r_coef    [0:U-1];
    logic signed [DATA_WIDTH-1:0]  r_dly_p0  [0:TAPS-1];
    logic signed [W1-1:0]          r_pre_p1  [0:U-1];
    logic signed [W2-1:0]          r_prod_p2 [0:U-1];
    logic signed [W3-1:0]          r_sum_p3;
    logic signed [OUT_WIDTH-1:0]   r_out_data;
    logic                          r_sat;
    logic                          r_vld_p0, r_vld_p1, r_vld_p2, r_vld_p3, r_out_valid;

    logic                          w_adv;
    logic                          w_accept;
    logic signed [W1-1:0]          w_pre  [0:U-1];
    logic signed [W2-1:0]          w_prod [0:U-1];
    logic signed [W3-1:0]          w_sum;
    logic [OUT_WIDTH:0]            w_sat;

    assign w_adv     = !r_out_valid || out_ready;
    assign in_ready  = w_adv && !coeff_we && !clr;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign sat_flag  = r_sat;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < U; i++) r_coef[i] <= '0;
        end else if (coeff_we && (int'(coeff_addr) < U)) begin
            r_coef[coeff_addr] <= coeff_data;
        end
    end

    // p0: delay line, newest sample at index 0
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < TAPS; i++) r_dly_p0[i] <= '0;
        end else if (w_accept) begin
            r_dly_p0[0] <= in_data;
            for (int i = TAPS - 1; i > 0; i--) r_dly_p0[i] <= r_dly_p0[i-1];
        end
    end

    // p1: fold mirrored taps; an odd centre tap passes through alone
    always_comb begin
        w_pre = '{default: '0};
        for (int k = 0; k < U; k++) begin
            if (k < HALF)
                w_pre[k] = W1'(r_dly_p0[k]) + W1'(r_dly_p0[TAPS-1-k]);
            else
                w_pre[k] = W1'(r_dly_p0[k]);
        end
    end

    // p2: one multiply per unique coefficient
    always_comb begin
        w_prod = '{default: '0};
        for (int k = 0; k < U; k++) w_prod[k] = W2'(r_pre_p1[k]) * W2'(r_coef[k]);
    end

    // p3: sum of products, width grown so no partial sum can wrap
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < U; k++) w_sum = w_sum + W3'(r_prod_p2[k]);
    end

    // p4: round, shift and clip into the output register
    assign w_sat = f_sat(f_round(r_sum_p3));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_vld_p0    <= 1'b0;
            r_vld_p1    <= 1'b0;
            r_vld_p2    <= 1'b0;
            r_vld_p3    <= 1'b0;
            r_out_valid <= 1'b0;
            for (int k = 0; k < U; k++) begin
                r_pre_p1[k]  <= '0;
                r_prod_p2[k] <= '0;
            end
            r_sum_p3   <= '0;
            r_out_data <= '0;
            r_sat      <= 1'b0;
        end else if (w_adv) begin
            r_vld_p0    <= w_accept;
            r_vld_p1    <= r_vld_p0;
            r_vld_p2    <= r_vld_p1;
            r_vld_p3    <= r_vld_p2;
            r_out_valid <= r_vld_p3;
            for (int k = 0; k < U; k++) begin
                r_pre_p1[k]  <= w_pre[k];
                r_prod_p2[k] <= w_prod[k];
            end
            r_sum_p3 <= w_sum;
            if (r_vld_p3) begin
                r_out_data <= w_sat[OUT_WIDTH-1:0];
                r_sat      <= w_sat[OUT_WIDTH];
            end else begin
                r_sat <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sym_fir_stream.sv
// Scoreboard bench for sym_fir_stream: four configurations (N=6, N=5, 8-bit saturating, SHIFT=2),
// directed impulse/saturation/rounding cases, random backpressure against a direct-form model, mid-flight clear.
module tb_sym_fir_stream;

    localparam int NI = 4;

    typedef struct packed {
        logic               sat;
        logic signed [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    clr;
    logic                    iv   [NI];
    logic signed [11:0]      id   [NI];
    logic                    ordy [NI];
    logic                    irdy [NI];
    logic                    ov   [NI];
    logic                    osat [NI];
    logic                    we   [NI];
    logic signed [7:0]       cd   [NI];
    logic [1:0]              ca0, ca1;
    logic                    ca2, ca3;
    logic signed [23:0]      od0, od1, od3;
    logic signed [7:0]       od2;
    int                      odx  [NI];

    sym_fir_stream #(.DATA_WIDTH(12), .COEFF_WIDTH(8), .TAPS(6), .OUT_WIDTH(24), .SHIFT(0)) u_n6 (
        .clk(clk), .clr(clr), .coeff_we(we[0]), .coeff_addr(ca0), .coeff_data(cd[0]),
        .in_valid(iv[0]), .in_ready(irdy[0]), .in_data(id[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od0), .sat_flag(osat[0]));

    sym_fir_stream #(.DATA_WIDTH(12), .COEFF_WIDTH(8), .TAPS(5), .OUT_WIDTH(24), .SHIFT(0)) u_n5 (
        .clk(clk), .clr(clr), .coeff_we(we[1]), .coeff_addr(ca1), .coeff_data(cd[1]),
        .in_valid(iv[1]), .in_ready(irdy[1]), .in_data(id[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od1), .sat_flag(osat[1]));

    sym_fir_stream #(.DATA_WIDTH(12), .COEFF_WIDTH(8), .TAPS(2), .OUT_WIDTH(8), .SHIFT(0)) u_sat (
        .clk(clk), .clr(clr), .coeff_we(we[2]), .coeff_addr(ca2), .coeff_data(cd[2]),
        .in_valid(iv[2]), .in_ready(irdy[2]), .in_data(id[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od2), .sat_flag(osat[2]));

    sym_fir_stream #(.DATA_WIDTH(12), .COEFF_WIDTH(8), .TAPS(2), .OUT_WIDTH(24), .SHIFT(2)) u_rnd (
        .clk(clk), .clr(clr), .coeff_we(we[3]), .coeff_addr(ca3), .coeff_data(cd[3]),
        .in_valid(iv[3]), .in_ready(irdy[3]), .in_data(id[3]),
        .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(od3), .sat_flag(osat[3]));

    always_comb begin
        odx[0] = od0;
        odx[1] = od1;
        odx[2] = od2;
        odx[3] = od3;
    end

    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   first_cyc [NI];
    int   last_acc;
    exp_t q0[$], q1[$], q2[$], q3[$];
    int   cf [3];
    int   h0 [6];
    logic rnd_done;
    int   mon_n;
    exp_t mon_e;

    task automatic chk_val(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    function automatic exp_t mk(input int v, input logic s);
        exp_t e;
        e.val = v;
        e.sat = s;
        return e;
    endfunction

    function automatic int qsize(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic void qpush(input int i, input exp_t e);
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endfunction

    function automatic exp_t qpop(input int i);
        exp_t e;
        e = '0;
        case (i)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            2: e = q2.pop_front();
            default: e = q3.pop_front();
        endcase
        return e;
    endfunction

    // Direct-form reference for the N=6 instance: y = sum c[k] * x[n-k], mirrored coefficients.
    function automatic exp_t model6();
        longint acc;
        exp_t   e;
        acc = 0;
        for (int k = 0; k < 6; k++)
            acc += longint'(cf[(k < 3) ? k : 5 - k]) * longint'(h0[k]);
        e = mk(32'(acc), 1'b0);
        if (acc > 8388607)       e = mk(8388607, 1'b1);
        else if (acc < -8388608) e = mk(-8388608, 1'b1);
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!clr && ov[i] && ordy[i]) begin
                mon_n = qsize(i);
                chk_val($sformatf("u%0d_output_expected", i), mon_n > 0, 1);
                if (mon_n > 0) begin
                    mon_e = qpop(i);
                    chk_val($sformatf("u%0d_data", i), odx[i], mon_e.val);
                    chk_val($sformatf("u%0d_sat", i), osat[i], mon_e.sat);
                    if (first_cyc[i] < 0) first_cyc[i] = cyc;
                end
            end
        end
    end

    task automatic wr_coef(input int i, input int a, input int d);
        we[i] = 1'b1;
        cd[i] = 8'(d);
        case (i)
            0: ca0 = a[1:0];
            1: ca1 = a[1:0];
            2: ca2 = a[0];
            default: ca3 = a[0];
        endcase
        @(negedge clk);
        chk_val($sformatf("u%0d_in_ready_during_we", i), irdy[i], 0);
        @(posedge clk);
        #1;
        we[i] = 1'b0;
    endtask

    task automatic send(input int i, input int x, input exp_t e);
        int w;
        w = 0;
        iv[i] = 1'b1;
        id[i] = 12'(x);
        @(negedge clk);
        while (!irdy[i] && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!irdy[i]) begin
            chk_val($sformatf("u%0d_in_ready_wait", i), irdy[i], 1);
        end else begin
            qpush(i, e);
            last_acc = cyc + 1;
        end
        @(posedge clk);
        #1;
        iv[i] = 1'b0;
    endtask

    task automatic drain(input int i);
        int w;
        w = 0;
        while (qsize(i) > 0 && w < 2000) begin
            @(posedge clk);
            w++;
        end
        #1;
        chk_val($sformatf("u%0d_drain_left", i), qsize(i), 0);
    endtask

    task automatic impulse6();
        int a0;
        first_cyc[0] = -1;
        send(0, 1, mk(1, 1'b0));
        a0 = last_acc;
        send(0, 0, mk(2, 1'b0));
        send(0, 0, mk(3, 1'b0));
        send(0, 0, mk(3, 1'b0));
        send(0, 0, mk(2, 1'b0));
        send(0, 0, mk(1, 1'b0));
        drain(0);
        chk_val("n6_latency", first_cyc[0] - a0, 4);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cnt;
        int   x;
        exp_t e;
        clr = 1'b1;
        for (int i = 0; i < NI; i++) begin
            iv[i] = 1'b0; id[i] = '0; ordy[i] = 1'b1; we[i] = 1'b0; cd[i] = '0;
            first_cyc[i] = -1;
        end
        ca0 = '0; ca1 = '0; ca2 = 1'b0; ca3 = 1'b0;
        rnd_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_val("rst_out_valid", ov[0], 0);
        chk_val("rst_in_ready", irdy[0], 0);
        chk_val("rst_out_data", odx[0], 0);
        chk_val("rst_sat", osat[0], 0);
        clr = 1'b0;
        @(posedge clk);
        #1;
        chk_val("in_ready_after_rst", irdy[0], 1);

        // N=6 impulse; the address-3 write lies beyond the three unique coefficients
        wr_coef(0, 0, 1);
        wr_coef(0, 1, 2);
        wr_coef(0, 2, 3);
        wr_coef(0, 3, 50);
        impulse6();

        // N=5 impulse with a lone centre tap
        wr_coef(1, 0, 1);
        wr_coef(1, 1, 2);
        wr_coef(1, 2, 4);
        send(1, 1, mk(1, 1'b0));
        send(1, 0, mk(2, 1'b0));
        send(1, 0, mk(4, 1'b0));
        send(1, 0, mk(2, 1'b0));
        send(1, 0, mk(1, 1'b0));
        drain(1);

        // 8-bit output clipping, both rails, then flag release
        wr_coef(2, 0, 127);
        send(2, 2047, mk(127, 1'b1));
        send(2, 2047, mk(127, 1'b1));
        send(2, -2048, mk(-127, 1'b0));
        send(2, -2048, mk(-128, 1'b1));
        send(2, 0, mk(-128, 1'b1));
        send(2, 0, mk(0, 1'b0));
        drain(2);

        // SHIFT=2 round-half-up then arithmetic shift
        wr_coef(3, 0, 1);
        send(3, 3, mk(1, 1'b0));
        send(3, 0, mk(1, 1'b0));
        send(3, -3, mk(-1, 1'b0));
        send(3, 0, mk(-1, 1'b0));
        send(3, 2, mk(1, 1'b0));
        send(3, -4, mk(0, 1'b0));
        send(3, 0, mk(-1, 1'b0));
        drain(3);

        // Random stream on N=6; the impulse above leaves only the 1 in the oldest tap
        for (int k = 0; k < 6; k++) h0[k] = 0;
        h0[5] = 1;
        for (int k = 0; k < 3; k++) begin
            cf[k] = int'($urandom_range(0, 255)) - 128;
            wr_coef(0, k, cf[k]);
        end
        fork
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    ordy[0] = ($urandom_range(0, 99) < 60);
                end
            end
            begin
                for (int n = 0; n < 1000; n++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    x = int'($urandom_range(0, 4095)) - 2048;
                    for (int k = 5; k > 0; k--) h0[k] = h0[k-1];
                    h0[0] = x;
                    e = model6();
                    send(0, x, e);
                end
                rnd_done = 1'b1;
            end
        join
        ordy[0] = 1'b1;
        drain(0);

        // Clear with an output pending and three samples still inside the pipeline
        wr_coef(0, 0, 1);
        wr_coef(0, 1, 2);
        wr_coef(0, 2, 3);
        send(0, 5, mk(0, 1'b0));
        send(0, 6, mk(0, 1'b0));
        send(0, 7, mk(0, 1'b0));
        send(0, 8, mk(0, 1'b0));
        @(posedge clk);
        #1;
        chk_val("pre_clr_out_valid", ov[0], 1);
        clr = 1'b1;
        #1;
        chk_val("clr_out_valid", ov[0], 0);
        chk_val("clr_out_data", odx[0], 0);
        chk_val("clr_in_ready", irdy[0], 0);
        q0.delete();
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ov[0]) cnt++;
        end
        chk_val("no_out_after_clr", cnt, 0);
        wr_coef(0, 0, 1);
        wr_coef(0, 1, 2);
        wr_coef(0, 2, 3);
        impulse6();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sym_fir_stream.md
SYM_FIR_STREAM -- requirements
Module: sym_fir_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, signed input sample width.
REQ-002 SHALL have parameter COEFF_WIDTH, default 8, signed coefficient width.
REQ-003 SHALL have parameter TAPS, default 12, total filter length N, odd or even, legal range 2..64; U = ceil(N/2) unique coefficients.
REQ-004 SHALL have parameter OUT_WIDTH, default 24, signed output width.
REQ-005 SHALL have parameter SHIFT, default 0, right-shift applied with rounding before saturation.
REQ-006 SHALL have port clk, input, 1, rising-edge clock.
REQ-007 SHALL have port clr, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port coeff_we, input, 1, coefficient write strobe.
REQ-009 SHALL have port coeff_addr, input, clog2(U) (min 1), coefficient index 0..U-1.
REQ-010 SHALL have port coeff_data, input, COEFF_WIDTH, signed coefficient value.
REQ-011 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_data (input, DATA_WIDTH, signed).
REQ-012 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, OUT_WIDTH, signed).
REQ-013 SHALL have port sat_flag, output, 1, high with an out_data value that was clipped.

Function
REQ-014 SHALL compute y[n] = sum over k=0..N-1 of c[k]*x[n-k], with c[k] = c[N-1-k] and coefficient RAM entry i holding c[i] for i < U.
REQ-015 SHALL keep an N-deep delay line, zero after reset, shifting only on input acceptance (in_valid && in_ready).
REQ-016 SHALL produce one output per accepted sample, starting with the first sample after reset; no fill wait.
REQ-017 SHALL pipeline as: S1 pre-add x[k]+x[N-1-k] (odd N: centre tap passes alone, sign-extended); S2 multiply by c[k]; S3 full adder-tree sum; S4 round, shift, saturate into out_data.
REQ-018 SHALL deliver out_valid exactly 4 clk cycles after the acceptance edge when out_ready is held high.
REQ-019 SHALL use internal widths with no overflow: S1 DATA_WIDTH+1, S2 DATA_WIDTH+COEFF_WIDTH+1, S3 S2 width + clog2(U).
REQ-020 SHALL round in S4 by adding 2^(SHIFT-1) (SHIFT>0 only), then arithmetic right-shifting by SHIFT.
REQ-021 SHALL saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and assert sat_flag for that output only.
REQ-022 SHALL carry a valid bit per stage; the whole pipeline advances when adv = !out_valid || out_ready and holds all stage data otherwise.
REQ-023 SHALL drive in_ready = adv && !coeff_we; no sample is lost or duplicated under any backpressure pattern.
REQ-024 SHALL hold out_data and sat_flag stable while out_valid && !out_ready.
REQ-025 SHALL write coeff_data to entry coeff_addr on the coeff_we edge; new value used by samples accepted in later cycles; in-flight samples may use either value.
REQ-026 SHALL ignore writes with coeff_addr >= U.
REQ-027 SHALL allow simultaneous output handshake and input acceptance in one cycle, giving full throughput of one sample per clock.

Reset
REQ-028 SHALL on clr clear delay line, all stage registers and valid bits, out_valid=0, out_data=0, sat_flag=0, coefficients=0, immediately and regardless of clk.
REQ-029 SHALL drive in_ready=0 while clr is high and equal to adv from the first clk edge after clr deasserts.
REQ-030 SHALL discard in-flight samples on reset mid-operation; no out_valid appears for them afterward.

Verification
REQ-031 SHALL verify impulse, N=6, coeffs 1,2,3: input 1 then five 0s, out_ready=1 -> outputs 1,2,3,3,2,1; first output 4 cycles after acceptance.
REQ-032 SHALL verify odd N=5, coeffs 1,2,4: input 1 then four 0s -> outputs 1,2,4,2,1.
REQ-033 SHALL verify saturation, OUT_WIDTH=8, N=2, coeff 127: input 2047 twice -> out_data 127 with sat_flag=1; input -2048 twice -> -128 with sat_flag=1.
REQ-034 SHALL verify rounding, SHIFT=2, N=2, coeff 1: input 3 then 0 -> raw sums 3 and 3 give outputs 1 and 1; input -3 then 0 -> outputs -1 and -1.
REQ-035 SHALL verify backpressure: random in_valid and out_ready toggling over 1000 samples -> output stream matches golden model exactly, with no drops or duplicates.
REQ-036 SHALL verify clr asserted with 3 samples in flight -> out_valid=0 immediately and the next impulse reproduces REQ-031 once coefficients are reloaded.
